cl_serial_driver: RTL

//   Bit-serial operand sequencer that drives the 1-bit logic cell (a, b, 2-bit

---
 rtl/cl_serial_if.sv | 27 ++
 rtl/cl_serial_driver.sv | 98 +++++++++
 2 files changed

// File: rtl/cl_serial_if.sv
// Bundle between the datapath, the serial driver and the 1-bit logic cell.
// Request: start/op/opa/opb. Cell: cl_a/cl_b/cl_s/cl_out. Status: busy/done/result.
interface cl_serial_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cl_a;
  logic             cl_b;
  logic [1:0]       cl_s;
  logic             cl_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, opa, opb, cl_out,
    input  cl_a, cl_b, cl_s, busy, done, result
  );

  modport slave (
    input  start, op, opa, opb, cl_out,
    output cl_a, cl_b, cl_s, busy, done, result
  );
endinterface

// File: rtl/cl_serial_driver.sv
// Bit-serial sequencer feeding a 1-bit logic cell LSB first and collecting results.
// Ports: clk, rst_n (sync, active low), bus (slave side of cl_serial_if).
module cl_serial_driver #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  cl_serial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cl_a_q, cl_a_d;
  logic             cl_b_q, cl_b_d;
  logic [1:0]       cl_s_q, cl_s_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cl_a_d  = 1'b0;
    cl_b_d  = 1'b0;
    cl_s_d  = cl_s_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start) begin
          a_d     = bus.opa;
          b_d     = bus.opb;
          cl_a_d  = bus.opa[0];
          cl_b_d  = bus.opb[0];
          cl_s_d  = bus.op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        // cell answer for the bit on the wires enters at the MSB
        res_d = {bus.cl_out, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          cl_a_d = a_q[1];
          cl_b_d = b_q[1];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cl_a_q  <= 1'b0;
      cl_b_q  <= 1'b0;
      cl_s_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cl_a_q  <= cl_a_d;
      cl_b_q  <= cl_b_d;
      cl_s_q  <= cl_s_d;
    end
  end

  assign bus.cl_a   = cl_a_q;
  assign bus.cl_b   = cl_b_q;
  assign bus.cl_s   = cl_s_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;

endmodule
